// File: rtl/sim_run_sequencer.sv
// =============================================================================
// Module      : sim_run_sequencer
// Description : Clocked control for one processor simulation run. It loads the
//               program, runs the pipeline for a bounded number of cycles, then
//               walks the reg-file and data-memory read ports for dumps.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module sim_run_sequencer #(
    parameter int PROG_LEN   = 17,
    parameter int IDX_W      = 5,
    parameter int RUN_CYCLES = 50,
    parameter int REG_PAIRS  = 16,
    parameter int MEM_BYTES  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             halt,
    input  logic [31:0]      prog_word,
    output logic [IDX_W-1:0] load_idx,
    output logic [31:0]      instr_addr,
    output logic [31:0]      instr_in,
    output logic             instr_write,
    output logic             instr_read,
    output logic             pc_reset,
    output logic             pc_write,
    output logic             initializing,
    output logic             ending,
    output logic [4:0]       end_read_reg1,
    output logic [4:0]       end_read_reg2,
    output logic [31:0]      end_mem_addr,
    output logic             dump_valid,
    output logic             dump_sel,
    output logic [15:0]      cycle_no,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RUN      = 3'd2,
        S_DUMP_REG = 3'd3,
        S_DUMP_MEM = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [IDX_W-1:0] C_LAST_IDX   = IDX_W'((PROG_LEN > 0) ? PROG_LEN - 1 : 0);
    localparam logic [15:0]      C_LAST_CYCLE = 16'(RUN_CYCLES - 1);
    localparam logic [4:0]       C_LAST_REG1  = 5'(2 * (REG_PAIRS - 1));
    localparam logic [31:0]      C_LAST_MEM   = 32'(MEM_BYTES - 1);
    localparam bit               C_SKIP_LOAD  = (PROG_LEN == 0);

    state_t           r_state;
    logic [IDX_W-1:0] r_loadIdx;
    logic             r_instrWrite;
    logic             r_instrRead;
    logic             r_pcReset;
    logic             r_pcWrite;
    logic             r_initializing;
    logic             r_ending;
    logic [4:0]       r_endReadReg1;
    logic [4:0]       r_endReadReg2;
    logic [31:0]      r_endMemAddr;
    logic             r_dumpValid;
    logic             r_dumpSel;
    logic [15:0]      r_cycleNo;
    logic             r_busy;
    logic             r_done;

    // Each transition programs the outputs of the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_loadIdx      <= '0;
            r_instrWrite   <= 1'b0;
            r_instrRead    <= 1'b0;
            r_pcReset      <= 1'b1;
            r_pcWrite      <= 1'b0;
            r_initializing <= 1'b1;
            r_ending       <= 1'b0;
            r_endReadReg1  <= '0;
            r_endReadReg2  <= '0;
            r_endMemAddr   <= '0;
            r_dumpValid    <= 1'b0;
            r_dumpSel      <= 1'b0;
            r_cycleNo      <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_cycleNo <= '0;
                        r_loadIdx <= '0;
                        r_done    <= 1'b0;
                        r_ending  <= 1'b0;
                        r_busy    <= 1'b1;
                        if (C_SKIP_LOAD) begin
                            r_state        <= S_RUN;
                            r_pcReset      <= 1'b0;
                            r_initializing <= 1'b0;
                            r_pcWrite      <= 1'b1;
                            r_instrRead    <= 1'b1;
                        end else begin
                            r_state        <= S_LOAD;
                            r_instrWrite   <= 1'b1;
                            r_pcReset      <= 1'b1;
                            r_initializing <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (r_loadIdx == C_LAST_IDX) begin
                        r_state        <= S_RUN;
                        r_loadIdx      <= '0;
                        r_instrWrite   <= 1'b0;
                        r_pcReset      <= 1'b0;
                        r_initializing <= 1'b0;
                        r_pcWrite      <= 1'b1;
                        r_instrRead    <= 1'b1;
                    end else begin
                        r_loadIdx <= r_loadIdx + 1'b1;
                    end
                end
                S_RUN: begin
                    // cycle_no freezes on exit so the run length stays visible.
                    if (halt || (r_cycleNo == C_LAST_CYCLE)) begin
                        r_state       <= S_DUMP_REG;
                        r_pcWrite     <= 1'b0;
                        r_instrRead   <= 1'b0;
                        r_ending      <= 1'b1;
                        r_dumpValid   <= 1'b1;
                        r_dumpSel     <= 1'b0;
                        r_endReadReg1 <= 5'd0;
                        r_endReadReg2 <= 5'd1;
                    end else begin
                        r_cycleNo <= r_cycleNo + 16'd1;
                    end
                end
                S_DUMP_REG: begin
                    if (r_endReadReg1 == C_LAST_REG1) begin
                        r_state      <= S_DUMP_MEM;
                        r_dumpSel    <= 1'b1;
                        r_endMemAddr <= '0;
                    end else begin
                        r_endReadReg1 <= r_endReadReg1 + 5'd2;
                        r_endReadReg2 <= r_endReadReg2 + 5'd2;
                    end
                end
                S_DUMP_MEM: begin
                    if (r_endMemAddr == C_LAST_MEM) begin
                        r_state     <= S_DONE;
                        r_dumpValid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_endMemAddr <= r_endMemAddr + 32'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign load_idx      = r_loadIdx;
    assign instr_addr    = {{(30 - IDX_W){1'b0}}, r_loadIdx, 2'b00};
    assign instr_in      = prog_word;
    assign instr_write   = r_instrWrite;
    assign instr_read    = r_instrRead;
    assign pc_reset      = r_pcReset;
    assign pc_write      = r_pcWrite;
    assign initializing  = r_initializing;
    assign ending        = r_ending;
    assign end_read_reg1 = r_endReadReg1;
    assign end_read_reg2 = r_endReadReg2;
    assign end_mem_addr  = r_endMemAddr;
    assign dump_valid    = r_dumpValid;
    assign dump_sel      = r_dumpSel;
    assign cycle_no      = r_cycleNo;
    assign busy          = r_busy;
    assign done          = r_done;

endmodule

`default_nettype wire

// File: tb/tb_sim_run_sequencer.sv
// =============================================================================
// Module      : tb_sim_run_sequencer
// Description : Directed self-checking bench; a 3-word program on one instance
//               and an empty program on a second.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_sim_run_sequencer;

    localparam logic [31:0] C_WORD_A = 32'hA1A1_0001;
    localparam logic [31:0] C_WORD_B = 32'hB2B2_0002;
    localparam logic [31:0] C_WORD_C = 32'hC3C3_0003;

    logic        clk = 1'b0;
    logic        reset, start, halt, start2;
    logic [31:0] progWord;

    logic [4:0]  loadIdx, loadIdx2;
    logic [31:0] instrAddr, instrIn, endMemAddr, instrAddr2, instrIn2, endMemAddr2;
    logic        instrWrite, instrRead, pcReset, pcWrite, initializing, ending;
    logic        instrWrite2, instrRead2, pcReset2, pcWrite2, initializing2, ending2;
    logic [4:0]  reg1, reg2, reg1b, reg2b;
    logic        dumpValid, dumpSel, busy, done;
    logic        dumpValid2, dumpSel2, busy2, done2;
    logic [15:0] cycleNo, cycleNo2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (loadIdx)
            5'd0:    progWord = C_WORD_A;
            5'd1:    progWord = C_WORD_B;
            5'd2:    progWord = C_WORD_C;
            default: progWord = 32'h0;
        endcase
    end

    sim_run_sequencer #(.PROG_LEN(3), .IDX_W(5), .RUN_CYCLES(5), .REG_PAIRS(16), .MEM_BYTES(64)) dut (
        .clk(clk), .reset(reset), .start(start), .halt(halt), .prog_word(progWord),
        .load_idx(loadIdx), .instr_addr(instrAddr), .instr_in(instrIn),
        .instr_write(instrWrite), .instr_read(instrRead), .pc_reset(pcReset),
        .pc_write(pcWrite), .initializing(initializing), .ending(ending),
        .end_read_reg1(reg1), .end_read_reg2(reg2), .end_mem_addr(endMemAddr),
        .dump_valid(dumpValid), .dump_sel(dumpSel), .cycle_no(cycleNo),
        .busy(busy), .done(done)
    );

    sim_run_sequencer #(.PROG_LEN(0), .IDX_W(5), .RUN_CYCLES(5), .REG_PAIRS(16), .MEM_BYTES(64)) dut0 (
        .clk(clk), .reset(reset), .start(start2), .halt(1'b0), .prog_word(32'hDEAD_BEEF),
        .load_idx(loadIdx2), .instr_addr(instrAddr2), .instr_in(instrIn2),
        .instr_write(instrWrite2), .instr_read(instrRead2), .pc_reset(pcReset2),
        .pc_write(pcWrite2), .initializing(initializing2), .ending(ending2),
        .end_read_reg1(reg1b), .end_read_reg2(reg2b), .end_mem_addr(endMemAddr2),
        .dump_valid(dumpValid2), .dump_sel(dumpSel2), .cycle_no(cycleNo2),
        .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; halt = 1'b0; start2 = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst pc_reset", pcReset, 1);
        chk("rst initializing", initializing, 1);
        chk("rst instr_write", instrWrite, 0);
        chk("rst pc_write", pcWrite, 0);
        chk("rst instr_read", instrRead, 0);
        chk("rst ending", ending, 0);
        chk("rst dump_valid", dumpValid, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst cycle_no", cycleNo, 0);
        chk("rst load_idx", loadIdx, 0);
        chk("rst end_mem_addr", endMemAddr, 0);

        reset = 1'b0;
        @(negedge clk);
        chk("idle pc_reset", pcReset, 1);
        start = 1'b1;

        // LOAD: three words at 0,4,8
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("load%0d instr_write", k), instrWrite, 1);
            chk($sformatf("load%0d load_idx", k), loadIdx, k);
            chk($sformatf("load%0d instr_addr", k), instrAddr, 4 * k);
            chk($sformatf("load%0d instr_in", k), instrIn, (k == 0) ? C_WORD_A : (k == 1) ? C_WORD_B : C_WORD_C);
            chk($sformatf("load%0d pc_reset", k), pcReset, 1);
            chk($sformatf("load%0d initializing", k), initializing, 1);
            chk($sformatf("load%0d busy", k), busy, 1);
        end

        // RUN for RUN_CYCLES; a start pulse mid-run is ignored
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b1;
            if (k == 2) start = 1'b0;
            chk($sformatf("run%0d pc_write", k), pcWrite, 1);
            chk($sformatf("run%0d cycle_no", k), cycleNo, k);
            chk($sformatf("run%0d instr_write", k), instrWrite, 0);
            chk($sformatf("run%0d instr_read", k), instrRead, 1);
            chk($sformatf("run%0d pc_reset", k), pcReset, 0);
            chk($sformatf("run%0d initializing", k), initializing, 0);
            chk($sformatf("run%0d load_idx", k), loadIdx, 0);
        end

        // DUMP_REG: pairs (0,1)..(30,31)
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk($sformatf("dreg%0d reg1", i), reg1, 2 * i);
            chk($sformatf("dreg%0d reg2", i), reg2, 2 * i + 1);
            chk($sformatf("dreg%0d dump_sel", i), dumpSel, 0);
            chk($sformatf("dreg%0d dump_valid", i), dumpValid, 1);
            chk($sformatf("dreg%0d ending", i), ending, 1);
            chk($sformatf("dreg%0d pc_write", i), pcWrite, 0);
            chk($sformatf("dreg%0d cycle_no", i), cycleNo, 4);
        end

        // DUMP_MEM: addresses 0..63
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            chk($sformatf("dmem%0d addr", j), endMemAddr, j);
            chk($sformatf("dmem%0d dump_sel", j), dumpSel, 1);
            chk($sformatf("dmem%0d dump_valid", j), dumpValid, 1);
        end

        @(negedge clk);
        chk("done done", done, 1);
        chk("done dump_valid", dumpValid, 0);
        chk("done busy", busy, 0);
        chk("done ending", ending, 1);
        chk("done pc_write", pcWrite, 0);
        chk("done cycle_no", cycleNo, 4);
        start = 1'b1;

        // Restart from DONE, halt at cycle_no=2
        @(negedge clk);
        start = 1'b0;
        chk("rs done", done, 0);
        chk("rs cycle_no", cycleNo, 0);
        chk("rs instr_write", instrWrite, 1);
        chk("rs load_idx0", loadIdx, 0);
        @(negedge clk);
        chk("rs load_idx1", loadIdx, 1);
        @(negedge clk);
        chk("rs load_idx2", loadIdx, 2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("hrun%0d cycle_no", k), cycleNo, k);
            chk($sformatf("hrun%0d pc_write", k), pcWrite, 1);
            if (k == 2) halt = 1'b1;
        end
        @(negedge clk);
        halt = 1'b0;
        chk("halt ending", ending, 1);
        chk("halt pc_write", pcWrite, 0);
        chk("halt dump_sel", dumpSel, 0);
        chk("halt reg1", reg1, 0);
        chk("halt cycle_no", cycleNo, 2);
        @(negedge clk);
        chk("halt hold cycle_no", cycleNo, 2);
        chk("halt reg1 next", reg1, 2);

        // Async reset mid-dump
        reset = 1'b1;
        #1;
        chk("arst busy", busy, 0);
        chk("arst ending", ending, 0);
        chk("arst pc_reset", pcReset, 1);
        chk("arst dump_valid", dumpValid, 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rl load_idx0", loadIdx, 0);
        @(negedge clk);
        chk("rl load_idx1", loadIdx, 1);
        chk("rl instr_write", instrWrite, 1);

        // Async reset mid-LOAD at load_idx=1
        reset = 1'b1;
        #1;
        chk("lrst instr_write", instrWrite, 0);
        chk("lrst pc_reset", pcReset, 1);
        chk("lrst initializing", initializing, 1);
        chk("lrst load_idx", loadIdx, 0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        start2 = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rl2 load_idx", loadIdx, 0);
        chk("rl2 instr_addr", instrAddr, 0);
        chk("rl2 instr_in", instrIn, C_WORD_A);
        chk("rl2 instr_write", instrWrite, 1);

        // Empty program: straight to RUN, start during RUN ignored
        chk("p0 pc_write", pcWrite2, 1);
        chk("p0 instr_read", instrRead2, 1);
        chk("p0 cycle_no", cycleNo2, 0);
        chk("p0 instr_write", instrWrite2, 0);
        chk("p0 initializing", initializing2, 0);
        chk("p0 pc_reset", pcReset2, 0);
        chk("p0 busy", busy2, 1);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            chk($sformatf("p0 run%0d cycle_no", k), cycleNo2, k);
            chk($sformatf("p0 run%0d pc_write", k), pcWrite2, 1);
            chk($sformatf("p0 run%0d instr_write", k), instrWrite2, 0);
        end
        @(negedge clk);
        chk("p0 dump ending", ending2, 1);
        chk("p0 dump sel", dumpSel2, 0);
        chk("p0 dump cycle_no", cycleNo2, 4);
        chk("p0 dump instr_write", instrWrite2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
